// File: rtl/sad_disparity_scheduler.sv
// Per-pixel disparity sweep: issues every legal candidate to the SAD datapath,
// folds returning sums into a running minimum, and hands the winner downstream.
module sad_disparity_scheduler #(
   parameter int MAX_DISP = 16,
   parameter int DISP_W   = 5,
   parameter int SAD_W    = 12,
   parameter int COL_W    = 11
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              pix_valid_in,
   input  logic [COL_W-1:0]  pix_col_in,
   output logic              pix_ready_out,
   output logic              req_valid_out,
   output logic [DISP_W-1:0] req_disp_out,
   input  logic              req_ready_in,
   input  logic              sad_valid_in,
   input  logic [SAD_W-1:0]  sad_in,
   output logic              res_valid_out,
   output logic [DISP_W-1:0] res_disp_out,
   output logic [SAD_W-1:0]  res_sad_out,
   input  logic              res_ready_in
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [DISP_W:0]  L_NMAX    = (DISP_W+1)'(MAX_DISP);
   localparam logic [COL_W-1:0] L_COL_SAT = COL_W'(MAX_DISP - 1);
   localparam logic [DISP_W:0]  L_ONE     = (DISP_W+1)'(1);

   logic [1:0]        r_state;
   logic [DISP_W:0]   r_n_cand;
   logic [DISP_W:0]   r_issue_cnt;
   logic [DISP_W:0]   r_ret_cnt;
   logic [SAD_W-1:0]  r_best_sad;
   logic [DISP_W-1:0] r_best_disp;
   logic [SAD_W-1:0]  r_res_sad;
   logic [DISP_W-1:0] r_res_disp;

   logic              w_fire;
   logic              w_consume;
   logic              w_better;
   logic              w_last_issue;
   logic              w_last_ret;
   logic [SAD_W-1:0]  w_cand_sad;
   logic [DISP_W-1:0] w_cand_disp;
   logic [DISP_W:0]   w_n_cand;

   // Disparities beyond the column index would look left of the image edge.
   assign w_n_cand = (pix_col_in >= L_COL_SAT) ? L_NMAX
                                                : (DISP_W+1)'(pix_col_in) + L_ONE;

   assign w_fire       = (r_state == S_ISSUE) && req_ready_in;
   assign w_consume    = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) &&
                         sad_valid_in && (r_ret_cnt != r_n_cand);
   assign w_better     = sad_in < r_best_sad;
   assign w_cand_sad   = w_better ? sad_in : r_best_sad;
   assign w_cand_disp  = w_better ? r_ret_cnt[DISP_W-1:0] : r_best_disp;
   assign w_last_issue = w_fire && ((r_issue_cnt + L_ONE) == r_n_cand);
   assign w_last_ret   = w_consume && ((r_ret_cnt + L_ONE) == r_n_cand);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state     <= S_IDLE;
         r_n_cand    <= '0;
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
         r_best_sad  <= '1;
         r_best_disp <= '0;
         r_res_sad   <= '1;
         r_res_disp  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (pix_valid_in) begin
                  r_n_cand    <= w_n_cand;
                  r_issue_cnt <= '0;
                  r_ret_cnt   <= '0;
                  r_best_sad  <= '1;
                  r_best_disp <= '0;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE, S_DRAIN: begin
               if (w_fire) begin
                  r_issue_cnt <= r_issue_cnt + L_ONE;
               end
               if (w_consume) begin
                  r_ret_cnt   <= r_ret_cnt + L_ONE;
                  r_best_sad  <= w_cand_sad;
                  r_best_disp <= w_cand_disp;
               end
               // A zero-latency final return can complete the job straight from ISSUE.
               if (w_last_ret) begin
                  r_res_sad  <= w_cand_sad;
                  r_res_disp <= w_cand_disp;
                  r_state    <= S_DONE;
               end else if (w_last_issue) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DONE: begin
               if (res_ready_in) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pix_ready_out = (r_state == S_IDLE);
   assign req_valid_out = (r_state == S_ISSUE);
   assign req_disp_out  = r_issue_cnt[DISP_W-1:0];
   assign res_valid_out = (r_state == S_DONE);
   assign res_disp_out  = r_res_disp;
   assign res_sad_out   = r_res_sad;

endmodule

// File: tb/tb_sad_disparity_scheduler.sv
// Directed bench for sad_disparity_scheduler: a SAD-datapath responder model
// feeds table-driven sums back, and a monitor scores each delivered result.
module tb_sad_disparity_scheduler;

   localparam int MAX_DISP = 16;
   localparam int DISP_W   = 5;
   localparam int SAD_W    = 12;
   localparam int COL_W    = 11;

   logic              clk;
   logic              rst_n;
   logic              pix_valid_in;
   logic [COL_W-1:0]  pix_col_in;
   logic              pix_ready_out;
   logic              req_valid_out;
   logic [DISP_W-1:0] req_disp_out;
   logic              req_ready_in;
   logic              sad_valid_in;
   logic [SAD_W-1:0]  sad_in;
   logic              res_valid_out;
   logic [DISP_W-1:0] res_disp_out;
   logic [SAD_W-1:0]  res_sad_out;
   logic              res_ready_in;

   sad_disparity_scheduler #(
      .MAX_DISP(MAX_DISP), .DISP_W(DISP_W), .SAD_W(SAD_W), .COL_W(COL_W)
   ) dut (
      .clk_in(clk), .rst_n_in(rst_n),
      .pix_valid_in(pix_valid_in), .pix_col_in(pix_col_in), .pix_ready_out(pix_ready_out),
      .req_valid_out(req_valid_out), .req_disp_out(req_disp_out), .req_ready_in(req_ready_in),
      .sad_valid_in(sad_valid_in), .sad_in(sad_in),
      .res_valid_out(res_valid_out), .res_disp_out(res_disp_out), .res_sad_out(res_sad_out),
      .res_ready_in(res_ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int d; int due; } pend_t;
   typedef struct { int d; int s; int n; } exp_t;

   pend_t pq[$];
   exp_t  sb[$];
   int    sad_tbl[64];
   int    checks = 0;
   int    failures = 0;
   int    exp_issue = 0;
   int    lat = 1;
   int    bp_mode = 0;
   int    bp_idx = 0;
   int    cyc = 0;
   int    stray_req = 0;
   int    ok;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // SAD datapath model: takes requests, returns table sums in order after lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (bp_mode != 0) begin
            req_ready_in = ((bp_idx % 3) == 0);
            bp_idx++;
         end else begin
            req_ready_in = 1'b1;
         end
         if (req_valid_out) begin
            check("req_disp_order", int'(req_disp_out), exp_issue);
            if (req_ready_in) begin
               pq.push_back('{d: int'(req_disp_out), due: cyc + lat});
               exp_issue++;
            end
         end
         sad_valid_in = 1'b0;
         if (stray_req != 0 && res_valid_out) begin
            sad_valid_in = 1'b1;
            sad_in       = '0;
            stray_req    = 0;
         end else if (pq.size() > 0 && pq[0].due <= cyc) begin
            sad_valid_in = 1'b1;
            sad_in       = SAD_W'(sad_tbl[pq[0].d]);
            void'(pq.pop_front());
         end
      end
   end

   // Result monitor: scores every consumed result against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && res_valid_out && res_ready_in) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               check("res_disp", int'(res_disp_out), e.d);
               check("res_sad", int'(res_sad_out), e.s);
               check("issued_count", exp_issue, e.n);
            end
         end
      end
   end

   task automatic wait_res();
      ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (res_valid_out) begin
            ok = 1;
            break;
         end
      end
      check("res_valid_timeout", ok, 1);
   endtask

   task automatic start_job(input int col, input int n, input int ed, input int es);
      check("pix_ready_before_job", int'(pix_ready_out), 1);
      exp_issue    = 0;
      bp_idx       = 0;
      sb.push_back('{d: ed, s: es, n: n});
      pix_col_in   = COL_W'(col);
      pix_valid_in = 1'b1;
      @(posedge clk); #1;
      pix_valid_in = 1'b0;
   endtask

   task automatic run_job(input int col, input int n, input int ed, input int es,
                          input int hold, input int keep_pix);
      start_job(col, n, ed, es);
      wait_res();
      for (int i = 0; i < hold; i++) begin
         pix_valid_in = (keep_pix != 0);
         check("hold_res_valid", int'(res_valid_out), 1);
         check("hold_pix_ready", int'(pix_ready_out), 0);
         check("hold_res_disp", int'(res_disp_out), ed);
         @(posedge clk); #1;
      end
      pix_valid_in = 1'b0;
      res_ready_in = 1'b1;
      @(posedge clk); #1;
      res_ready_in = 1'b0;
      check("bubble_pix_ready", int'(pix_ready_out), 1);
      check("bubble_res_valid", int'(res_valid_out), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got %0d expected %0d", 0, 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      pix_valid_in = 1'b0;
      pix_col_in = '0;
      req_ready_in = 1'b1;
      sad_valid_in = 1'b0;
      sad_in = '0;
      res_ready_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pix_ready", int'(pix_ready_out), 1);
      check("rst_req_valid", int'(req_valid_out), 0);
      check("rst_req_disp", int'(req_disp_out), 0);
      check("rst_res_valid", int'(res_valid_out), 0);
      check("rst_res_disp", int'(res_disp_out), 0);
      check("rst_res_sad", int'(res_sad_out), 4095);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // V-shaped SAD minimum at d=9, two-cycle return latency.
      for (int d = 0; d < 64; d++) sad_tbl[d] = ((d > 9) ? (d - 9) : (9 - d)) * 10 + 3;
      lat = 2;
      run_job(20, 16, 9, 3, 3, 0);

      // Column 3 limits the sweep to four candidates; tie keeps the lower disparity.
      sad_tbl[0] = 50; sad_tbl[1] = 40; sad_tbl[2] = 40; sad_tbl[3] = 60;
      lat = 1;
      run_job(3, 4, 1, 40, 0, 0);

      // Request backpressure with zero-latency returns gives the same winner.
      for (int d = 0; d < 64; d++) sad_tbl[d] = ((d > 9) ? (d - 9) : (9 - d)) * 10 + 3;
      lat = 0;
      bp_mode = 1;
      run_job(20, 16, 9, 3, 0, 0);
      bp_mode = 0;

      // Saturated sums stay at d=0; a stray return in DONE must not disturb the result.
      for (int d = 0; d < 64; d++) sad_tbl[d] = 4095;
      lat = 1;
      start_job(100, 16, 0, 4095);
      wait_res();
      stray_req = 1;
      repeat (3) @(posedge clk);
      #1;
      check("stray_res_disp", int'(res_disp_out), 0);
      check("stray_res_sad", int'(res_sad_out), 4095);
      res_ready_in = 1'b1;
      @(posedge clk); #1;
      res_ready_in = 1'b0;

      // Asynchronous reset while issuing d=7.
      lat = 2;
      start_job(20, 16, 0, 0);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (exp_issue == 7) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reach_issue7", ok, 1);
      check("pre_rst_req_disp", int'(req_disp_out), 7);
      rst_n = 1'b0;
      void'(sb.pop_back());
      pq.delete();
      #1;
      check("mid_rst_pix_ready", int'(pix_ready_out), 1);
      check("mid_rst_req_valid", int'(req_valid_out), 0);
      check("mid_rst_req_disp", int'(req_disp_out), 0);
      check("mid_rst_res_valid", int'(res_valid_out), 0);
      check("mid_rst_res_sad", int'(res_sad_out), 4095);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      sad_tbl[0] = 77;
      run_job(0, 1, 0, 77, 0, 0);

      // Downstream stalls ten cycles while a new pixel is already offered.
      for (int d = 0; d < 64; d++) sad_tbl[d] = 200 - d * 5;
      lat = 1;
      run_job(5, 6, 5, 175, 10, 1);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
